// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: memory read port, instruction output buffer and redirect.
// The master side is the fetch unit; the slave side is memory plus the downstream stage.
interface fetch_unit_if;
  logic        mem_read;
  logic [15:0] mem_address;
  logic [31:0] mem_data;
  logic        mem_busy;
  logic [31:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        fault;

  modport master (
    output mem_read, mem_address, instr, instr_pc, instr_valid, fault,
    input  mem_data, mem_busy, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  mem_read, mem_address, instr, instr_pc, instr_valid, fault,
    output mem_data, mem_busy, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one-word reads at PC, holds the result in a
// single-entry output buffer, honours redirects and flags out-of-range fetches.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int          MEM_DEPTH = 512
) (
  input  logic          i_clock,
  input  logic          i_reset_n,
  fetch_unit_if.master  io_bus
);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [16:0] DEPTH_EXT = 17'(MEM_DEPTH);

  state_t      r_state;
  state_t      w_next_state;
  logic        r_run;
  logic [15:0] r_pc;
  logic [31:0] r_instr;
  logic [15:0] r_instr_pc;
  logic        r_instr_valid;
  logic        r_fault;

  logic        w_in_range;
  logic        w_transfer;
  logic        w_mem_read;
  logic        w_capture;
  logic        w_fault_set;

  assign w_in_range = ({1'b0, r_pc} < DEPTH_EXT);
  assign w_transfer = r_instr_valid & io_bus.instr_ready;

  // Next-state and strobe decode; r_run keeps the port quiet until the first edge after reset.
  always_comb begin
    w_next_state = r_state;
    w_mem_read   = 1'b0;
    w_capture    = 1'b0;
    w_fault_set  = 1'b0;
    case (r_state)
      ST_REQ: begin
        if (io_bus.branch_taken) begin
          w_next_state = ST_REQ;
        end else if (!r_run) begin
          w_next_state = ST_REQ;
        end else if (!w_in_range) begin
          w_next_state = ST_FAULT;
          w_fault_set  = 1'b1;
        end else if (!io_bus.mem_busy && (!r_instr_valid || io_bus.instr_ready)) begin
          w_mem_read   = 1'b1;
          w_next_state = ST_WAIT;
        end else begin
          w_next_state = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (io_bus.branch_taken) begin
          w_next_state = ST_REQ;
        end else begin
          w_capture    = 1'b1;
          w_next_state = ST_REQ;
        end
      end
      ST_FAULT: begin
        if (io_bus.branch_taken) begin
          w_next_state = ST_REQ;
        end else begin
          w_next_state = ST_FAULT;
        end
      end
      default: begin
        w_next_state = ST_REQ;
      end
    endcase
  end

  // State register and post-reset run enable.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_REQ;
      r_run   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_run   <= 1'b1;
    end
  end

  // PC, output buffer and sticky fault; a redirect overrides everything else.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_pc          <= RESET_PC;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 16'h0000;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else if (io_bus.branch_taken) begin
      r_pc          <= io_bus.branch_target;
      r_instr_valid <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      if (w_capture) begin
        r_instr       <= io_bus.mem_data;
        r_instr_pc    <= r_pc;
        r_instr_valid <= 1'b1;
        r_pc          <= r_pc + 16'd1;
      end else if (w_transfer) begin
        r_instr_valid <= 1'b0;
      end else begin
        r_instr_valid <= r_instr_valid;
      end
      if (w_fault_set) begin
        r_fault <= 1'b1;
      end else begin
        r_fault <= r_fault;
      end
    end
  end

  assign io_bus.mem_read    = w_mem_read;
  assign io_bus.mem_address = r_pc;
  assign io_bus.instr       = r_instr;
  assign io_bus.instr_pc    = r_instr_pc;
  assign io_bus.instr_valid = r_instr_valid;
  assign io_bus.fault       = r_fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_fetch_unit;

  localparam int DEPTH = 512;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_bad;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(16'h0000), .MEM_DEPTH(DEPTH)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .io_bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mem [0:DEPTH-1];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'hC0DE_0000 ^ 32'(i);
    mem[0]      = 32'h0880_0002;
    mem[16'h10] = 32'h1234_5678;
    mem[9'h1FF] = 32'hDEAD_BEEF;
  end

  // Memory returns the word in the cycle after the edge that sampled the strobe.
  always @(posedge clk) begin
    if (bus.mem_read) bus.mem_data <= mem[bus.mem_address[8:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a read is either in flight or not; the buffer holds one word.
  logic        m_run;
  logic [15:0] m_pc;
  logic        m_pending;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [15:0] m_ipc;
  logic        m_fault;
  logic        e_read;
  logic        e_fault_hit;

  assign e_read = m_run && !m_pending && !m_fault && (m_pc < 16'(DEPTH)) &&
                  !bus.branch_taken && !bus.mem_busy && (!m_valid || bus.instr_ready);
  assign e_fault_hit = m_run && !m_pending && !m_fault && (m_pc >= 16'(DEPTH)) &&
                       !bus.branch_taken;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_pc <= 16'h0000; m_pending <= 1'b0; m_valid <= 1'b0;
      m_instr <= 32'h0; m_ipc <= 16'h0; m_fault <= 1'b0;
    end else begin
      m_run <= 1'b1;
      if (bus.branch_taken) begin
        m_pc <= bus.branch_target; m_valid <= 1'b0; m_fault <= 1'b0; m_pending <= 1'b0;
      end else begin
        if (m_pending) begin
          m_instr <= mem[m_pc[8:0]]; m_ipc <= m_pc; m_valid <= 1'b1;
          m_pc <= m_pc + 16'd1; m_pending <= 1'b0;
        end else if (m_valid && bus.instr_ready) begin
          m_valid <= 1'b0;
        end
        if (e_read) m_pending <= 1'b1;
        if (e_fault_hit) m_fault <= 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("mem_read", 32'(bus.mem_read), 32'(e_read));
    chk("mem_address", 32'(bus.mem_address), 32'(m_pc));
    chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
    chk("instr", bus.instr, m_instr);
    chk("instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
    chk("fault", 32'(bus.fault), 32'(m_fault));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_bad = 0;
    rst_n = 1'b0;
    bus.instr_ready = 1'b1; bus.mem_busy = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
    #3;
    chk("rst_read", 32'(bus.mem_read), 32'd0);
    chk("rst_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_addr", 32'(bus.mem_address), 32'd0);
    #20 rst_n = 1'b1;
    #1 chk("pre_edge_read", 32'(bus.mem_read), 32'd0);

    // First fetch after reset
    tick(); #1 chk("c0_read", 32'(bus.mem_read), 32'd1);
    chk("c0_addr", 32'(bus.mem_address), 32'h0);
    tick(); #1 chk("wait_read", 32'(bus.mem_read), 32'd0);
    tick(); #1 chk("cap0_valid", 32'(bus.instr_valid), 32'd1);
    chk("cap0_instr", bus.instr, 32'h0880_0002);
    chk("cap0_pc", 32'(bus.instr_pc), 32'h0);
    chk("next_addr", 32'(bus.mem_address), 32'h1);
    chk("next_read", 32'(bus.mem_read), 32'd1);

    // Backpressure
    bus.instr_ready = 1'b0;
    #1 chk("bp_read", 32'(bus.mem_read), 32'd0);
    repeat (3) tick();
    #1 chk("bp_instr", bus.instr, 32'h0880_0002);
    chk("bp_pc", 32'(bus.instr_pc), 32'h0);
    chk("bp_valid", 32'(bus.instr_valid), 32'd1);
    bus.instr_ready = 1'b1;
    #1 chk("rel_read", 32'(bus.mem_read), 32'd1);
    chk("rel_addr", 32'(bus.mem_address), 32'h1);
    tick(); #1 chk("xfer_valid", 32'(bus.instr_valid), 32'd0);
    tick(); #1 chk("cap1_pc", 32'(bus.instr_pc), 32'h1);

    // MemBusy for three cycles
    bus.mem_busy = 1'b1;
    #1 chk("busy_read0", 32'(bus.mem_read), 32'd0);
    tick(); #1 chk("busy_read1", 32'(bus.mem_read), 32'd0);
    tick(); #1 chk("busy_read2", 32'(bus.mem_read), 32'd0);
    tick(); bus.mem_busy = 1'b0;
    #1 chk("unbusy_read", 32'(bus.mem_read), 32'd1);
    chk("unbusy_addr", 32'(bus.mem_address), 32'h2);

    // Redirect while in WAIT discards the returning word
    tick(); bus.branch_taken = 1'b1; bus.branch_target = 16'h0010;
    #1 chk("br_wait_read", 32'(bus.mem_read), 32'd0);
    tick(); bus.branch_taken = 1'b0;
    #1 chk("br_valid", 32'(bus.instr_valid), 32'd0);
    chk("br_held_pc", 32'(bus.instr_pc), 32'h1);
    chk("br_read", 32'(bus.mem_read), 32'd1);
    chk("br_addr", 32'(bus.mem_address), 32'h10);
    tick(); tick();
    #1 chk("cap10_instr", bus.instr, 32'h1234_5678);
    chk("cap10_pc", 32'(bus.instr_pc), 32'h10);

    // MemBusy rising in WAIT does not disturb the capture
    tick(); bus.mem_busy = 1'b1;
    tick(); #1 chk("busywait_pc", 32'(bus.instr_pc), 32'h11);
    chk("busywait_valid", 32'(bus.instr_valid), 32'd1);
    bus.mem_busy = 1'b0;

    // Redirect in REQ suppresses the read; then run off the end of memory
    bus.branch_taken = 1'b1; bus.branch_target = 16'h01FF;
    #1 chk("br_req_read", 32'(bus.mem_read), 32'd0);
    tick(); bus.branch_taken = 1'b0;
    #1 chk("b1ff_addr", 32'(bus.mem_address), 32'h1FF);
    chk("b1ff_read", 32'(bus.mem_read), 32'd1);
    tick(); tick();
    #1 chk("cap1ff_instr", bus.instr, 32'hDEAD_BEEF);
    chk("cap1ff_pc", 32'(bus.instr_pc), 32'h1FF);
    chk("pc200", 32'(bus.mem_address), 32'h200);
    chk("oob_read", 32'(bus.mem_read), 32'd0);
    bus.instr_ready = 1'b0;
    tick(); #1 chk("fault_set", 32'(bus.fault), 32'd1);
    chk("fault_pending", 32'(bus.instr_valid), 32'd1);
    bus.instr_ready = 1'b1;
    tick(); #1 chk("fault_xfer", 32'(bus.instr_valid), 32'd0);
    tick(); #1 chk("fault_read", 32'(bus.mem_read), 32'd0);
    chk("fault_sticky", 32'(bus.fault), 32'd1);
    bus.branch_taken = 1'b1; bus.branch_target = 16'h0000;
    tick(); bus.branch_taken = 1'b0;
    #1 chk("fault_clr", 32'(bus.fault), 32'd0);
    chk("resume_read", 32'(bus.mem_read), 32'd1);
    chk("resume_addr", 32'(bus.mem_address), 32'h0);

    // Reset asserted mid-WAIT
    tick(); tick(); tick();
    #1 rst_n = 1'b0;
    #1 chk("mr_valid", 32'(bus.instr_valid), 32'd0);
    chk("mr_instr", bus.instr, 32'h0);
    chk("mr_ipc", 32'(bus.instr_pc), 32'h0);
    chk("mr_addr", 32'(bus.mem_address), 32'h0);
    chk("mr_read", 32'(bus.mem_read), 32'd0);
    tick(); tick();
    rst_n = 1'b1;
    #1 chk("mr_rel_read", 32'(bus.mem_read), 32'd0);
    tick(); #1 chk("mr_first_read", 32'(bus.mem_read), 32'd1);
    chk("mr_first_addr", 32'(bus.mem_address), 32'h0);
    tick(); tick();
    #1 chk("mr_cap_instr", bus.instr, 32'h0880_0002);
    chk("mr_cap_pc", 32'(bus.instr_pc), 32'h0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, SHALL set the word address fetched first after reset.
REQ-002 Parameter MEM_DEPTH, default 512, SHALL set the number of valid instruction words; addresses >= MEM_DEPTH SHALL fault.
REQ-003 Clock  in  1  SHALL be the single clock; all state updates on posedge.
REQ-004 Reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 MemRead  out  1  SHALL be the read strobe to unified memory.
REQ-006 MemAddress  out  16  SHALL be the word address to memory; it always equals PC.
REQ-007 MemData  in  32  SHALL be memory read data, valid in the cycle after the edge that sampled MemRead=1.
REQ-008 MemBusy  in  1  SHALL, when high, indicate that the data stage owns the memory port; fetch SHALL NOT assert MemRead.
REQ-009 Instr  out  32  SHALL be the fetched instruction word.
REQ-010 InstrPC  out  16  SHALL be the address Instr came from.
REQ-011 InstrValid  out  1  SHALL indicate that Instr/InstrPC hold an undelivered instruction.
REQ-012 InstrReady  in  1  SHALL be the downstream accept signal; transfer occurs on an edge with InstrValid=1 and InstrReady=1.
REQ-013 BranchTaken  in  1  SHALL request a PC redirect.
REQ-014 BranchTarget  in  16  SHALL be the redirect address, sampled when BranchTaken=1.
REQ-015 Fault  out  1  SHALL be the sticky out-of-range fetch flag.

Function
REQ-016 The FSM SHALL have states REQ, WAIT and FAULT, plus a one-entry output buffer (InstrValid/Instr/InstrPC).
REQ-017 In REQ, MemRead SHALL be 1 iff MemBusy=0, PC < MEM_DEPTH, BranchTaken=0, and (InstrValid=0 or InstrReady=1); in all other cases MemRead SHALL be 0.
REQ-018 REQ->WAIT SHALL occur on the edge where MemRead=1; otherwise the FSM SHALL stay in REQ.
REQ-019 REQ->FAULT SHALL occur when PC >= MEM_DEPTH and BranchTaken=0; Fault SHALL go to 1 on that edge and MemRead SHALL stay 0.
REQ-020 In WAIT, on the next edge the unit SHALL load Instr<=MemData, InstrPC<=PC, InstrValid<=1, PC<=PC+1 (16-bit, wrapping FFFF->0000), and go to REQ.
REQ-021 Latency SHALL be 2 cycles from MemRead assertion to InstrValid; peak throughput SHALL be one instruction per 2 cycles.
REQ-022 InstrValid SHALL clear on a transfer edge unless a WAIT capture occurs on the same edge, in which case the new word SHALL replace the old one.
REQ-023 While InstrValid=1 and InstrReady=0, Instr/InstrPC SHALL hold stable.
REQ-024 BranchTaken=1 SHALL take priority in every state: PC<=BranchTarget, InstrValid<=0, Fault<=0, next state REQ.
REQ-025 A redirect in WAIT SHALL discard the returning MemData.
REQ-026 A redirect SHALL NOT issue a read in the same cycle.
REQ-027 FAULT SHALL be left only by a redirect or reset; MemRead SHALL be 0 in FAULT.
REQ-028 A pending InstrValid word SHALL remain deliverable in FAULT.
REQ-029 MemBusy rising while in WAIT SHALL NOT affect the capture, because the read was already sampled.

Reset
REQ-030 Reset_n=0 SHALL immediately force state=REQ, PC=RESET_PC, InstrValid=0, Instr=0, InstrPC=0, Fault=0, MemRead=0, independent of Clock.
REQ-031 Reset asserted in WAIT SHALL abandon the read; after release, the first read SHALL be at RESET_PC.
REQ-032 The first MemRead after release SHALL be no earlier than the first posedge with Reset_n=1.

Verification
REQ-033 Release reset with InstrReady=1, MemBusy=0, and memory[0]=32'h08800002 -> MemRead=1 @0 in cycle 0; InstrValid=1, Instr=08800002, InstrPC=0 after edge 2; the next read is @1.
REQ-034 Hold InstrReady=0 after the first capture -> MemRead stays 0 and Instr/InstrPC stay stable; raising InstrReady -> transfer, with the next read @1 in the same cycle.
REQ-035 Hold MemBusy=1 for 3 cycles in REQ -> no MemRead for 3 cycles; the read @PC issues in the first cycle with MemBusy=0.
REQ-036 Assert BranchTaken with BranchTarget=16'h0010 while in WAIT -> MemData is discarded, InstrValid=0, and the next read is @0010 one cycle later.
REQ-037 Redirect to 16'h01FF with MEM_DEPTH=512 -> word 1FF is delivered, then PC=0200, Fault=1 with no further MemRead; a redirect to 0 clears Fault and fetch resumes.
REQ-038 Assert Reset_n=0 mid-WAIT between edges -> outputs clear immediately; after release the first read is @RESET_PC.
